// File: rtl/cs_pkg.sv
// Shared CS parameters, used by the CS averager, its output buffer and their benches.
package cs_pkg;
  localparam int CS_WIN = 9;   // sliding-window length in samples
  localparam int CS_XW  = 8;   // CS input sample width
  localparam int CS_YW  = 10;  // CS averaged output width
endpackage

// File: rtl/cs_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an explicit level count.
module cs_sync_fifo
  import cs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = CS_YW,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // NOTE: the storage array has no reset; only pointers and level do, so the
  // array maps onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Head is masked while empty so stale or uninitialised entries never show.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cs_out_buffer.sv
// CS output buffer: waits out the window warm-up, then streams every average
// through a small FIFO, counting samples dropped while the consumer stalls.
module cs_out_buffer
  import cs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIN   = CS_WIN,
  parameter int DW    = CS_YW,
  parameter int DCW   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DW-1:0]              y_in,
  output logic [DW-1:0]              m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       warm,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [DCW-1:0]             drop_cnt
);
  localparam int WCW = $clog2(WIN + 1);
  localparam int LW  = $clog2(DEPTH) + 1;

  logic [WCW-1:0] wcnt;
  logic           push;
  logic           pop;
  logic           drop;
  logic           full;
  logic           empty;

  always_ff @(posedge clk) begin
    if (reset)                  wcnt <= '0;
    else if (wcnt != WCW'(WIN)) wcnt <= wcnt + WCW'(1);
  end

  assign warm    = (wcnt == WCW'(WIN));
  assign push    = warm;
  assign m_valid = !empty;
  assign pop     = m_valid && m_ready;
  assign drop    = push && full && !pop;

  cs_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .LW    (LW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (y_in),
    .rdata (m_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Both drop indicators are sticky until reset; the count saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DCW'(1);
    end
  end

endmodule

// File: tb/tb_cs_out_buffer.sv
// Self-checking bench for cs_out_buffer: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_cs_out_buffer;
  import cs_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIN   = CS_WIN;
  localparam int DW    = CS_YW;
  localparam int DCW   = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int DMAX  = (1 << DCW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] y_in = '0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          warm;
  logic [LW-1:0] level;
  logic          overflow;
  logic [DCW-1:0] drop_cnt;

  always #5 clk = ~clk;

  cs_out_buffer #(
    .DEPTH (DEPTH),
    .WIN   (WIN),
    .DW    (DW),
    .DCW   (DCW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .y_in     (y_in),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .warm     (warm),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: edges since reset, a queue of buffered values, drop tally.
  int  m_edges = 0;
  int  q[$];
  bit  m_ovf = 0;
  int  m_drop = 0;
  int  n_push = 0;
  int  rx[$];
  bit  chk_en = 0;
  bit  m_push, m_pop;

  task automatic model_step();
    if (reset) begin
      m_edges = 0;
      q.delete();
      m_ovf   = 0;
      m_drop  = 0;
      n_push  = 0;
      chk_en  = 1;
    end else begin
      if (m_valid === 1'b1 && m_ready) rx.push_back(int'(m_data));
      m_push = (m_edges >= WIN);
      m_pop  = (q.size() != 0) && m_ready;
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        n_push++;
        if (q.size() < DEPTH) q.push_back(int'(y_in));
        else begin
          m_ovf = 1;
          if (m_drop < DMAX) m_drop++;
        end
      end
      if (m_edges < 1000) m_edges++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("level", level, q.size());
      check("m_valid", m_valid, q.size() != 0);
      if (q.size() != 0) check("m_data", m_data, q[0]);
      check("warm", warm, m_edges >= WIN);
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_drop);
    end
  end

  // One reset edge, literal post-reset checks, release before the next edge (E1).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_level", level, 0);
    check("rst_valid", m_valid, 0);
    check("rst_warm", warm, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_m_data", m_data, 0);
    reset = 1'b0;
  endtask

  initial begin
    int bad;

    // Constant input, consumer always ready.
    do_reset();
    y_in = 10'd22;
    m_ready = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check("t1_warm", warm, k >= 9);
      check("t1_valid", m_valid, k >= 10);
      if (k >= 10) check("t1_data", m_data, 22);
      if (k >= 10) check("t1_level", level, 1);
      check("t1_overflow", overflow, 0);
    end

    // Fill with a stalled consumer, overflow on value 9, then drain.
    do_reset();
    m_ready = 1'b0;
    rx.delete();
    for (int k = 1; k <= 18; k++) begin
      y_in = (k >= 10) ? DW'(k - 9) : '0;
      @(negedge clk);
      if (k == 17) begin
        check("t2_level_full", level, 8);
        check("t2_no_ovf_yet", overflow, 0);
      end
    end
    check("t2_level_after_drop", level, 8);
    check("t2_overflow", overflow, 1);
    check("t2_drop_cnt", drop_cnt, 1);

    // Full FIFO with simultaneous push and pop: no drop, level held.
    m_ready = 1'b1;
    for (int k = 19; k <= 30; k++) begin
      y_in = DW'(k - 9);
      @(negedge clk);
      check("t3_level", level, 8);
      check("t3_drop_cnt", drop_cnt, 1);
    end
    check("t3_rx_count", rx.size(), 12);
    if (rx.size() >= 10) begin
      for (int i = 0; i < 8; i++) check("t2_rx_order", rx[i], i + 1);
      check("t3_rx_after_drop", rx[8], 10);
      check("t3_rx_contiguous", rx[9], 11);
    end

    // Long stall: counter saturates, flag stays.
    m_ready = 1'b0;
    for (int k = 0; k < 300; k++) begin
      y_in = y_in + DW'(1);
      @(negedge clk);
    end
    check("t4_drop_sat", drop_cnt, 255);
    check("t4_overflow", overflow, 1);
    check("t4_level", level, 8);

    // Reset while full and overflowed, then warm-up restarts.
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      y_in = DW'(k);
      @(negedge clk);
      if (k == 8) check("t5_warm_e8", warm, 0);
      if (k == 9) check("t5_warm_e9", warm, 1);
    end
    check("t5_level5", level, 5);
    check("t5_head", m_data, 10);
    do_reset();

    // Random back-pressure on a ramp: ordering and drop accounting.
    rx.delete();
    for (int c = 0; c < 300; c++) begin
      y_in = DW'(c % 1024);
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bad = 0;
    for (int i = 1; i < rx.size(); i++) if (rx[i] <= rx[i-1]) bad++;
    check("t6_order_violations", bad, 0);
    check("t6_push_count", n_push, 291);
    check("t6_accounting", rx.size() + int'(drop_cnt) + int'(level), 291);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cs_out_buffer.md
# cs_out_buffer

Output buffer placed directly downstream of the CS sliding-window averager. It tracks the CS window warm-up after reset and discards outputs until the 9-sample window is full. Valid 10-bit averages are captured into a small FIFO and presented on a valid/ready stream, so a consumer can stall briefly without losing results. Overflow is reported, not hidden.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2.
- WIN, 9, CS window length in samples (cycles after reset before Y is meaningful).
- DW, 10, data width; equals CS Y width.
- DCW, 8, drop counter width.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- y_in  in  DW  CS Y output, sampled every posedge.
- m_data  out  DW  head-of-FIFO data; reset 0.
- m_valid  out  1  FIFO non-empty; reset 0.
- m_ready  in  1  consumer accepts m_data this cycle.
- warm  out  1  CS window full, y_in valid; reset 0.
- level  out  $clog2(DEPTH)+1  entries held; reset 0.
- overflow  out  1  sticky, set on any drop; reset 0.
- drop_cnt  out  DCW  dropped samples, saturating; reset 0.

## Operation
- Warm-up counter wcnt counts posedges with reset low and saturates at WIN. warm = (wcnt == WIN).
- push = warm (pre-edge value). Every cycle with warm=1 carries a valid y_in, because CS produces one result per clock.
- pop = m_valid && m_ready.
- FIFO is first-word-fall-through: m_data = oldest entry; m_valid = (level != 0). m_data is don't-care when m_valid=0, but it is 0 after reset.
- Full (level == DEPTH):
  - push with pop: both happen; level is unchanged; no drop.
  - push without pop: y_in is discarded, FIFO is unchanged, overflow is set to 1, and drop_cnt increments unless it is at 2^DCW-1.
- Empty: pop is impossible (m_valid=0). A push and a pop cannot coincide on an empty FIFO. No read-through bypass.
- Pointers wrap modulo DEPTH. level is tracked explicitly, so full and empty are distinguished without pointer-MSB tricks.
- overflow and drop_cnt clear only on reset.
- Reset at any point clears wcnt, the pointers, level, overflow, drop_cnt and m_data. Buffered data is lost. The warm-up restarts, matching the CS register clear.

## Timing
- Reset released before edge E1: warm rises after edge E9 (wcnt=9).
- The first push occurs at E10. m_valid rises after E10 when the FIFO was empty, giving 1-cycle push-to-output latency.
- In steady state with m_ready held at 1, level oscillates 1↔1 and m_data equals y_in delayed by one cycle.
- level reflects post-edge state. The m_ready→pop decision is combinational on the current m_valid; no combinational path from m_ready to m_valid or m_data.
- All outputs are registered or decoded from registered state. There is no combinational path from y_in to any output.

## Structure
- Shared package cs_pkg holds CS_WIN=9, CS_XW=8 and CS_YW=10, and is also used by CS and its testbench. The defaults for WIN and DW are taken from it.
- One sub-module, cs_sync_fifo (DEPTH, DW): storage array, read/write pointers, level, full/empty, and first-word-fall-through head.
- The top level adds the warm-up counter, push/drop logic, the sticky flag and the saturating counter.

## Test plan
- Reset, then y_in=22 constant and m_ready=1: warm=0 through E9, warm=1 after E9, m_valid=0 until after E10, then m_data=22 every cycle; overflow=0.
- m_ready=0, y_in ramp 1,2,3… from E10: level reaches 8 after E17. The next push drops value 9, giving overflow=1 and drop_cnt=1. Then raise m_ready: the bench must read 1..8 in order.
- Full FIFO, m_ready=1 and push in the same cycle: level stays 8, drop_cnt is unchanged, and the output sequence is contiguous with no gap.
- m_ready=0 for 300 cycles after the FIFO fills: drop_cnt saturates at 255 and overflow stays 1.
- Reset asserted for one cycle with level=5 and overflow=1: after the edge, level=0, m_valid=0, overflow=0, drop_cnt=0, warm=0. warm returns only 9 edges after release.
- Random m_ready (50%), y_in ramp 0..1023: the received sequence is strictly ordered. Received count plus drop_cnt equals the number of pushes, and there are no drops while the stall run is shorter than DEPTH.
